// File: rtl/wb_pipe_reg_if.sv
// MEM->WB stage bus: upstream beat, downstream handshake and held writeback outputs.
// The master modport drives a stage; the slave modport is the stage itself.
interface wb_pipe_reg_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               valid_i;
    logic               ready_o;
    logic [DATA_W-1:0]  RDData_i;
    logic [DATA_W-1:0]  ALUResult_i;
    logic [RADDR_W-1:0] RDAddr_i;
    logic               RegWrite_i;
    logic               MemToReg_i;
    logic               flush_i;
    logic               valid_o;
    logic               ready_i;
    logic [DATA_W-1:0]  RDData_o;
    logic [DATA_W-1:0]  ALUResult_o;
    logic [RADDR_W-1:0] RDAddr_o;
    logic               RegWrite_o;
    logic               MemToReg_o;
    logic [DATA_W-1:0]  WBData_o;
    logic [CNT_W-1:0]   retired_o;

    modport master (
        output valid_i, RDData_i, ALUResult_i, RDAddr_i, RegWrite_i, MemToReg_i,
        output flush_i, ready_i,
        input  ready_o, valid_o, RDData_o, ALUResult_o, RDAddr_o,
        input  RegWrite_o, MemToReg_o, WBData_o, retired_o
    );

    modport slave (
        input  valid_i, RDData_i, ALUResult_i, RDAddr_i, RegWrite_i, MemToReg_i,
        input  flush_i, ready_i,
        output ready_o, valid_o, RDData_o, ALUResult_o, RDAddr_o,
        output RegWrite_o, MemToReg_o, WBData_o, retired_o
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: two-entry skid buffer (SKID=1) or single stalling register (SKID=0),
// with writeback-data select and a wrapping count of retired register writes.
module wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0]  rdData;
        logic [DATA_W-1:0]  aluResult;
        logic [RADDR_W-1:0] rdAddr;
        logic               regWrite;
        logic               memToReg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_p1;
    state_t           stateNext;
    entry_t           main_p1;
    entry_t           skid_p1;
    entry_t           mainNext;
    entry_t           skidNext;
    entry_t           inEntry;
    logic [CNT_W-1:0] retired_p1;
    logic             vld_p1;
    logic             readyOut;
    logic             inXfer;
    logic             outXfer;
    logic             retire;
    logic             regWriteGated;
    logic             memToRegGated;

    assign inEntry = {bus.RDData_i, bus.ALUResult_i, bus.RDAddr_i, bus.RegWrite_i, bus.MemToReg_i};
    assign vld_p1  = (state_p1 != EMPTY);

    // The skid variant derives ready from the held state only, breaking the ready_i path.
    generate
        if (SKID != 0) begin : g_skid
            assign readyOut = (state_p1 != TWO);
        end else begin : g_stall
            assign readyOut = bus.ready_i | ~vld_p1;
        end
    endgenerate

    assign inXfer        = bus.valid_i & readyOut;
    assign outXfer       = vld_p1 & bus.ready_i;
    assign regWriteGated = vld_p1 & main_p1.regWrite;
    assign memToRegGated = vld_p1 & main_p1.memToReg;
    assign retire        = outXfer & regWriteGated;

    always_comb begin
        stateNext = state_p1;
        mainNext  = main_p1;
        skidNext  = skid_p1;
        if (bus.flush_i) begin
            stateNext = EMPTY;
        end else begin
            unique case (state_p1)
                EMPTY: begin
                    if (inXfer) begin
                        stateNext = ONE;
                        mainNext  = inEntry;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        mainNext = inEntry;
                    end else if (inXfer) begin
                        stateNext = TWO;
                        skidNext  = inEntry;
                    end else if (outXfer) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (outXfer) begin
                        stateNext = ONE;
                        mainNext  = skid_p1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // p1: held entries, occupancy and retired counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1   <= EMPTY;
            main_p1    <= '0;
            skid_p1    <= '0;
            retired_p1 <= '0;
        end else begin
            state_p1 <= stateNext;
            main_p1  <= mainNext;
            skid_p1  <= skidNext;
            if (retire) begin
                retired_p1 <= retired_p1 + CNT_W'(1);
            end
        end
    end

    assign bus.ready_o     = readyOut;
    assign bus.valid_o     = vld_p1;
    assign bus.RDData_o    = main_p1.rdData;
    assign bus.ALUResult_o = main_p1.aluResult;
    assign bus.RDAddr_o    = main_p1.rdAddr;
    assign bus.RegWrite_o  = regWriteGated;
    assign bus.MemToReg_o  = memToRegGated;
    assign bus.WBData_o    = memToRegGated ? main_p1.rdData : main_p1.aluResult;
    assign bus.retired_o   = retired_p1;
endmodule
